// File: rtl/bconv_scan_ctrl_pkg.sv
// Shared constants and state encoding for the binary 3x3 convolution scan controller.
package bconv_pkg;

    localparam int K        = 3;
    localparam int WIN_BITS = K * K;
    localparam int POP_W    = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SCAN  = 2'd1;
    localparam state_t ST_FLUSH = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/bconv_scan_ctrl_if.sv
// Result write port toward the output feature-map store (valid/ready with explicit address).
interface bconv_scan_ctrl_if #(
    parameter int ADDR_W = 10
);
    import bconv_pkg::*;

    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [POP_W-1:0]  out_data;

    modport master (output out_valid, output out_addr, output out_data, input out_ready);
    modport slave  (input out_valid, input out_addr, input out_data, output out_ready);

endinterface

// File: rtl/bconv_scan_ctrl_window_sel.sv
// Combinational 3x3 window extraction from the latched image at output position (r, c).
module bconv_window_sel
    import bconv_pkg::*;
#(
    parameter int INPUT_H = 28,
    parameter int INPUT_W = 28,
    parameter int ROW_W   = 5,
    parameter int COL_W   = 5
) (
    input  logic [INPUT_H*INPUT_W-1:0] img_i,
    input  logic [ROW_W-1:0]           r_i,
    input  logic [COL_W-1:0]           c_i,
    output logic [WIN_BITS-1:0]        win_o
);

    localparam int IDX_W = $clog2(INPUT_H * INPUT_W);

    logic [IDX_W-1:0] base0;
    logic [IDX_W-1:0] base1;
    logic [IDX_W-1:0] base2;

    // Top window row lands in the high bits; within a row, bit 0 of the slice is column c.
    always_comb begin
        base0 = IDX_W'(r_i) * IDX_W'(INPUT_W) + IDX_W'(c_i);
        base1 = base0 + IDX_W'(INPUT_W);
        base2 = base1 + IDX_W'(INPUT_W);
        win_o = {img_i[base0 +: K], img_i[base1 +: K], img_i[base2 +: K]};
    end

endmodule

// File: rtl/bconv_scan_ctrl.sv
// Raster-order scan sequencer for the binary 3x3 convolution: window issue and stallable result port.
//
//  state    | meaning
//  ---------+---------------------------------------------------------
//  ST_IDLE  | waiting for start; latches image and kernel on start
//  ST_SCAN  | issues one window per free output slot, raster order
//  ST_FLUSH | last result held until the consumer accepts it
//  ST_DONE  | done pulse, then back to idle
module bconv_scan_ctrl
    import bconv_pkg::*;
#(
    parameter int INPUT_H  = 28,
    parameter int INPUT_W  = 28,
    parameter int K_H      = 3,
    parameter int K_W      = 3,
    parameter int OUTPUT_H = INPUT_H - K_H + 1,
    parameter int OUTPUT_W = INPUT_W - K_W + 1,
    parameter int ADDR_W   = $clog2(OUTPUT_H * OUTPUT_W)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [INPUT_H*INPUT_W-1:0] image_i,
    input  logic [WIN_BITS-1:0]        kernel_i,
    output logic [WIN_BITS-1:0]        win_o,
    output logic [WIN_BITS-1:0]        kern_o,
    input  logic [POP_W-1:0]           pop_i,
    output logic                       busy,
    output logic                       done,
    bconv_scan_ctrl_if.master          wr
);

    localparam int ROW_W = $clog2(OUTPUT_H + 1);
    localparam int COL_W = $clog2(OUTPUT_W + 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUTPUT_H - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(OUTPUT_W - 1);

    state_t                     state_q, state_d;
    logic [ROW_W-1:0]           r_q, r_d;
    logic [COL_W-1:0]           c_q, c_d;
    logic [INPUT_H*INPUT_W-1:0] img_q, img_d;
    logic [WIN_BITS-1:0]        kern_q, kern_d;
    logic                       out_valid_q, out_valid_d;
    logic [ADDR_W-1:0]          out_addr_q, out_addr_d;
    logic [POP_W-1:0]           out_data_q, out_data_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;

    logic              slot_free;
    logic              last_pos;
    logic [ADDR_W-1:0] cur_addr;

    bconv_window_sel #(
        .INPUT_H (INPUT_H),
        .INPUT_W (INPUT_W),
        .ROW_W   (ROW_W),
        .COL_W   (COL_W)
    ) u_window_sel (
        .img_i (img_q),
        .r_i   (r_q),
        .c_i   (c_q),
        .win_o (win_o)
    );

    assign slot_free = !out_valid_q || wr.out_ready;
    assign last_pos  = (r_q == ROW_LAST) && (c_q == COL_LAST);
    assign cur_addr  = ADDR_W'(r_q) * ADDR_W'(OUTPUT_W) + ADDR_W'(c_q);

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        c_d         = c_q;
        img_d       = img_q;
        kern_d      = kern_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    img_d   = image_i;
                    kern_d  = kernel_i;
                    r_d     = '0;
                    c_d     = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                // A blocked slot freezes counters, so the window and pop_i stay put too.
                if (slot_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = pop_i;
                    out_addr_d  = cur_addr;
                    if (last_pos) begin
                        state_d = ST_FLUSH;
                    end else if (c_q == COL_LAST) begin
                        c_d = '0;
                        r_d = r_q + 1'b1;
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                if (wr.out_ready) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            r_q         <= '0;
            c_q         <= '0;
            img_q       <= '0;
            kern_q      <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            c_q         <= c_d;
            img_q       <= img_d;
            kern_q      <= kern_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign kern_o       = kern_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign wr.out_valid = out_valid_q;
    assign wr.out_addr  = out_addr_q;
    assign wr.out_data  = out_data_q;

endmodule

// File: tb/tb_bconv_scan_ctrl.sv
// Bench for bconv_scan_ctrl: 4x4 table vectors plus 28x28 backpressure/restart/reset/back-to-back scans.
module tb_bconv_scan_ctrl;
    import bconv_pkg::*;

    localparam int BIG_W     = 28;
    localparam int BIG_OW    = 26;
    localparam int BIG_N     = BIG_OW * BIG_OW;
    localparam int BIG_BOUND = 6000;
    localparam int NVEC      = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_sm, rst_bg, start_sm, start_bg;
    logic [15:0]  image_sm;
    logic [783:0] image_bg;
    logic [8:0]   kernel_sm, kernel_bg, win_sm, kern_sm, win_bg, kern_bg;
    logic [3:0]   pop_sm, pop_bg;
    logic         busy_sm, done_sm, busy_bg, done_bg;

    int n_chk = 0;
    int n_err = 0;

    bconv_scan_ctrl_if #(.ADDR_W(2))  if_sm ();
    bconv_scan_ctrl_if #(.ADDR_W(10)) if_bg ();

    // External XNOR_POPCOUNT unit.
    assign pop_sm = 4'($countones(~(win_sm ^ kern_sm)));
    assign pop_bg = 4'($countones(~(win_bg ^ kern_bg)));

    bconv_scan_ctrl #(.INPUT_H(4), .INPUT_W(4)) u_sm (
        .clk(clk), .rst(rst_sm), .start(start_sm), .image_i(image_sm), .kernel_i(kernel_sm),
        .win_o(win_sm), .kern_o(kern_sm), .pop_i(pop_sm), .busy(busy_sm), .done(done_sm), .wr(if_sm)
    );

    bconv_scan_ctrl #(.INPUT_H(28), .INPUT_W(28)) u_bg (
        .clk(clk), .rst(rst_bg), .start(start_bg), .image_i(image_bg), .kernel_i(kernel_bg),
        .win_o(win_bg), .kern_o(kern_bg), .pop_i(pop_bg), .busy(busy_bg), .done(done_bg), .wr(if_bg)
    );

    typedef struct packed {
        logic [15:0]     img;
        logic [8:0]      kern;
        logic [3:0][3:0] exp_d;
    } svec_t;

    svec_t tbl [NVEC];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [15:0] im, input logic [8:0] kn,
                           input logic [3:0] d0, input logic [3:0] d1,
                           input logic [3:0] d2, input logic [3:0] d3);
        tbl[i].img   = im;
        tbl[i].kern  = kn;
        tbl[i].exp_d = {d3, d2, d1, d0};
    endtask

    function automatic logic [783:0] rand_img();
        logic [783:0] v;
        for (int i = 0; i < 784; i++) v[i] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    // Reference window at output address a, built straight from the image bit layout.
    function automatic logic [3:0] exp_pop(input logic [783:0] img, input logic [8:0] kern, input int a);
        logic [8:0] w;
        int r, c;
        r = a / BIG_OW;
        c = a % BIG_OW;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                w[(2 - dr) * 3 + dc] = img[(r + dr) * BIG_W + c + dc];
        return 4'(9 - $countones(w ^ kern));
    endfunction

    task automatic sm_run(input int i);
        image_sm  = tbl[i].img;
        kernel_sm = tbl[i].kern;
        start_sm  = 1'b1;
        @(posedge clk); #1;
        start_sm  = 1'b0;
        image_sm  = ~tbl[i].img;
        chk("sm_valid_before_first", 32'(if_sm.out_valid), 0);
        chk("sm_busy_after_start", 32'(busy_sm), 1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("sm_valid", 32'(if_sm.out_valid), 1);
            chk("sm_addr", 32'(if_sm.out_addr), 32'(k));
            chk($sformatf("sm_data_v%0d_a%0d", i, k), 32'(if_sm.out_data), 32'(tbl[i].exp_d[k]));
            if (k == 0) chk("sm_kern_o", 32'(kern_sm), 32'(tbl[i].kern));
        end
        @(posedge clk); #1;
        chk("sm_done_pulse", 32'(done_sm), 1);
        chk("sm_valid_cleared", 32'(if_sm.out_valid), 0);
        chk("sm_busy_in_done", 32'(busy_sm), 1);
        @(posedge clk); #1;
        chk("sm_done_single", 32'(done_sm), 0);
        chk("sm_busy_idle", 32'(busy_sm), 0);
    endtask

    task automatic big_scan(input logic [783:0] img, input logic [8:0] kern, input bit rand_rdy,
                            input int glitch_at, input int rst_at);
        int         hs;
        bit         fin, aborted, stalled, last_prev, hit_rst, rdy;
        logic [9:0] p_addr;
        logic [3:0] p_data;
        hs = 0; fin = 0; aborted = 0; stalled = 0; last_prev = 0;
        p_addr = '0; p_data = '0;
        image_bg  = img;
        kernel_bg = kern;
        start_bg  = 1'b1;
        @(posedge clk); #1;
        start_bg  = 1'b0;
        image_bg  = ~img;
        kernel_bg = ~kern;
        chk("bg_busy_after_start", 32'(busy_bg), 1);
        chk("bg_kern_latched", 32'(kern_bg), 32'(kern));
        for (int cyc = 0; cyc < BIG_BOUND && !fin; cyc++) begin
            if (cyc == 0) chk("bg_first_valid_low", 32'(if_bg.out_valid), 0);
            if (cyc == 1) chk("bg_first_valid_high", 32'(if_bg.out_valid), 1);
            if (stalled) begin
                chk("bg_stall_valid", 32'(if_bg.out_valid), 1);
                chk("bg_stall_addr", 32'(if_bg.out_addr), 32'(p_addr));
                chk("bg_stall_data", 32'(if_bg.out_data), 32'(p_data));
            end
            if (last_prev) chk("bg_done_after_last", 32'(done_bg), 1);
            if (done_bg) begin
                fin = 1;
            end else begin
                rdy = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
                if_bg.out_ready = rdy;
                start_bg  = (hs == glitch_at);
                stalled   = if_bg.out_valid && !rdy;
                p_addr    = if_bg.out_addr;
                p_data    = if_bg.out_data;
                last_prev = 0;
                hit_rst   = 0;
                if (if_bg.out_valid && rdy) begin
                    chk("bg_addr_order", 32'(if_bg.out_addr), 32'(hs));
                    chk("bg_data", 32'(if_bg.out_data), 32'(exp_pop(img, kern, hs)));
                    if (hs == BIG_N - 1) last_prev = 1;
                    hs++;
                    if (hs == rst_at) begin
                        rst_bg  = 1'b1;
                        hit_rst = 1;
                    end
                end
                @(posedge clk); #1;
                if (hit_rst) begin
                    rst_bg = 1'b0;
                    chk("bg_rst_valid", 32'(if_bg.out_valid), 0);
                    chk("bg_rst_busy", 32'(busy_bg), 0);
                    chk("bg_rst_done", 32'(done_bg), 0);
                    chk("bg_rst_addr", 32'(if_bg.out_addr), 0);
                    chk("bg_rst_data", 32'(if_bg.out_data), 0);
                    chk("bg_rst_kern", 32'(kern_bg), 0);
                    chk("bg_rst_win", 32'(win_bg), 0);
                    aborted = 1;
                    fin     = 1;
                end
            end
        end
        start_bg = 1'b0;
        if (!fin) begin
            n_chk++;
            n_err++;
            $display("FAIL bg_timeout: got %0d handshakes without done, expected %0d", hs, BIG_N);
        end else if (!aborted) begin
            chk("bg_handshake_count", 32'(hs), 32'(BIG_N));
            @(posedge clk); #1;
            chk("bg_done_single", 32'(done_bg), 0);
            chk("bg_busy_idle", 32'(busy_bg), 0);
            chk("bg_valid_idle", 32'(if_bg.out_valid), 0);
        end
    endtask

    initial begin
        logic [783:0] img_a, img_b;
        set_vec(0,  16'hFFFF, 9'h1FF, 9, 9, 9, 9);
        set_vec(1,  16'hA5A5, 9'h1FF, 5, 4, 4, 5);
        set_vec(2,  16'hA5A5, 9'h155, 9, 0, 0, 9);
        set_vec(3,  16'h0000, 9'h1FF, 0, 0, 0, 0);
        set_vec(4,  16'hFFFF, 9'h000, 0, 0, 0, 0);
        set_vec(5,  16'h0000, 9'h000, 9, 9, 9, 9);
        set_vec(6,  16'h0001, 9'h1FF, 1, 0, 0, 0);
        set_vec(7,  16'h8000, 9'h1FF, 0, 0, 0, 1);
        set_vec(8,  16'h0010, 9'h1FF, 1, 0, 1, 0);
        set_vec(9,  16'h0004, 9'h1FF, 1, 1, 0, 0);
        set_vec(10, 16'h0001, 9'h000, 8, 9, 9, 9);

        img_a = rand_img();
        img_b = rand_img();
        rst_sm = 1'b1; rst_bg = 1'b1;
        start_sm = 1'b1; start_bg = 1'b1;
        image_sm = 16'hFFFF; kernel_sm = 9'h1FF;
        image_bg = img_a;    kernel_bg = 9'h1FF;
        if_sm.out_ready = 1'b1;
        if_bg.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sm_valid", 32'(if_sm.out_valid), 0);
        chk("rst_sm_busy", 32'(busy_sm), 0);
        chk("rst_sm_done", 32'(done_sm), 0);
        chk("rst_sm_addr", 32'(if_sm.out_addr), 0);
        chk("rst_sm_data", 32'(if_sm.out_data), 0);
        chk("rst_sm_win", 32'(win_sm), 0);
        chk("rst_sm_kern", 32'(kern_sm), 0);
        chk("rst_bg_valid", 32'(if_bg.out_valid), 0);
        chk("rst_bg_busy", 32'(busy_bg), 0);
        chk("rst_bg_win", 32'(win_bg), 0);
        chk("rst_bg_kern", 32'(kern_bg), 0);
        start_sm = 1'b0; start_bg = 1'b0;
        rst_sm = 1'b0; rst_bg = 1'b0;
        @(posedge clk); #1;
        chk("idle_sm_busy", 32'(busy_sm), 0);

        for (int i = 0; i < NVEC; i++) sm_run(i);

        // Random backpressure with an ignored start mid-scan.
        big_scan(img_a, 9'($urandom_range(0, 511)), 1'b1, 100, -1);
        // Reset lands on the 10th handshake.
        big_scan(img_b, 9'h0F0, 1'b0, -1, 10);
        // Fresh scan after reset, then a back-to-back frame with a new kernel.
        big_scan(img_b, 9'h1FF, 1'b0, -1, -1);
        big_scan(img_b, 9'h0A3, 1'b0, -1, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/bconv_scan_ctrl.md
Name: bconv_scan_ctrl

Overview:
Sequencer for the binary 3x3 convolution datapath. On `start` it latches one binary image and one kernel, then walks every valid output position in raster order. For each position it drives the 9-bit window into the external XNOR_POPCOUNT unit and streams each 4-bit popcount result out through a valid/ready write port with an explicit address. It sits between the layer buffer and the BConv output feature-map store, replacing free-running, unclocked index stepping with a deterministic, stallable scan.

Parameters:
- INPUT_H, 28, image rows
- INPUT_W, 28, image columns
- K_H, 3, kernel rows (fixed at 3; other values unsupported)
- K_W, 3, kernel columns (fixed at 3; other values unsupported)
- OUTPUT_H, INPUT_H-K_H+1, output rows (derived; do not override)
- OUTPUT_W, INPUT_W-K_W+1, output columns (derived; do not override)
- ADDR_W, $clog2(OUTPUT_H*OUTPUT_W), output address width

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle request to begin a scan; sampled only in IDLE
- image_i  in  INPUT_H*INPUT_W  flattened image; bit index r*INPUT_W+c
- kernel_i  in  9  flattened kernel; latched with image_i
- win_o  out  9  current window to XNOR_POPCOUNT
- kern_o  out  9  latched kernel to XNOR_POPCOUNT
- pop_i  in  4  combinational popcount of (win_o, kern_o), valid in the same cycle
- out_valid  out  1  result present on out_addr/out_data
- out_ready  in  1  consumer accepts the result when out_valid && out_ready
- out_addr  out  ADDR_W  r*OUTPUT_W+c of the result
- out_data  out  4  popcount result, range 0..9
- busy  out  1  high from the cycle after start is accepted through the DONE state
- done  out  1  one-cycle pulse after the last result is accepted

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state=IDLE; row/col counters 0; out_valid=0; out_addr=0; out_data=0; busy=0; done=0; latched image and kernel=0. win_o and kern_o derive from the latched registers, so both are 0.
- States:
  - IDLE: if start, latch image_i and kernel_i, clear r and c, go to SCAN.
  - SCAN: issue windows.
  - FLUSH: wait for the last result to be accepted.
  - DONE: assert done for 1 cycle, then go to IDLE.
- Window mapping at position (r,c), with bit 0 = lowest column:
  - win_o[8:6] = img[r*W+c +: 3]
  - win_o[5:3] = img[(r+1)*W+c +: 3]
  - win_o[2:0] = img[(r+2)*W+c +: 3]
  - W = INPUT_W. Bit 6 is image column c.
- Output slot: a single output register. Define slot_free = !out_valid || out_ready.
- SCAN stepping, when slot_free:
  - Load out_data<=pop_i, out_addr<=r*OUTPUT_W+c, out_valid<=1.
  - Advance c. At c==OUTPUT_W-1, wrap c to 0 and increment r.
  - If this position was (OUTPUT_H-1, OUTPUT_W-1), go to FLUSH instead of advancing.
- SCAN stepping, when !slot_free: hold r, c, out_* and win_o stable (stall).
- Throughput: one result per cycle with out_ready held high. The first out_valid appears 2 cycles after the start cycle (IDLE->SCAN, then register).
- Output clearing: in SCAN, out_valid drops only when accepted with no new issue. It is never cleared while unaccepted.
- FLUSH: on acceptance, out_valid<=0 and go to DONE. done is high the cycle after the final handshake, then returns to IDLE with busy=0.
- Ignored start: start in any non-IDLE state is ignored; no restart and no relatch.
- Mid-scan reset: rst mid-scan returns all of the above to reset values next cycle. A pending unaccepted result is dropped.
- Input stability: image_i and kernel_i changes after latching have no effect on the current scan.
- Counter width: derived from the parameters with no overflow; the address fits in ADDR_W.

Decomposition:
- Package bconv_pkg:
  - state enum {IDLE, SCAN, FLUSH, DONE}
  - localparam K=3 and WIN_BITS=9
  - popcount width 4
- Natural sub-module: bconv_window_sel, a combinational mux that takes (latched image, r, c) and produces win_o using the mapping above. The controller holds the FSM, counters and output register.

Test Plan:
- Small frame: INPUT_H=INPUT_W=4, all-ones image and kernel, out_ready=1 -> 4 results, addr 0,1,2,3 consecutive cycles, data 9 each; done pulses once the cycle after addr 3 is accepted.
- Known pattern: 4x4 image 0xA5A5 (row-major, bit 0 = r0c0), kernel 0x1FF -> each out_data equals the count of ones in the matching window; bench model checks all 4 addresses and data.
- Backpressure: 28x28 random image, out_ready toggled pseudo-randomly -> exactly 676 handshakes, addr 0..675 strictly in order, no duplicates, out_data/out_addr stable while stalled.
- Restart guard: start pulsed during SCAN -> ignored; handshake count unchanged, single done.
- Reset mid-scan: rst at the 10th handshake -> next cycle out_valid=0, busy=0, state IDLE. A new start then produces addr 0 first.
- Back-to-back frames: start asserted the cycle after done -> second full scan of 676 results with the newly latched kernel.
